// File: rtl/rcosine_pkg.sv
// Shared definitions for the raised-cosine serial FIR.
//   NTAP / NSTEP : tap count and MAC steps per output sample
//   CW           : coefficient width (signed)
//   H0..H4       : unique half of the symmetric impulse response, h(k) = h(8-k)
//   out_w()      : output / accumulator width for a given sample width
package rcosine_pkg;

    localparam int NTAP  = 9;
    localparam int NSTEP = 5;
    localparam int CW    = 8;

    localparam logic signed [CW-1:0] H0 = 8'sd0;
    localparam logic signed [CW-1:0] H1 = -8'sd6;
    localparam logic signed [CW-1:0] H2 = 8'sd0;
    localparam logic signed [CW-1:0] H3 = 8'sd38;
    localparam logic signed [CW-1:0] H4 = 8'sd64;

    // Headroom for a (DSIZE+1)-bit pre-sum times an 8-bit coefficient,
    // accumulated over five steps with a DC gain of 128.
    function automatic int out_w(input int dsize);
        return 2 * dsize + 3;
    endfunction

endpackage

// File: rtl/rcosine_mac.sv
// Pre-adder, single multiplier and accumulator for the folded FIR.
//   fast_clk, n_rst : processing clock, async active-low reset
//   clr             : zero the accumulator on the next edge (wins over en)
//   en              : accumulate the current product on the next edge
//   op_a, op_b      : symmetric tap pair, summed on DSIZE+1 bits
//   coef            : coefficient for this step
//   sum             : accumulator + current product (combinational)
module rcosine_mac
    import rcosine_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic                             fast_clk,
    input  logic                             n_rst,
    input  logic                             clr,
    input  logic                             en,
    input  logic signed [DSIZE-1:0]          op_a,
    input  logic signed [DSIZE-1:0]          op_b,
    input  logic signed [CW-1:0]             coef,
    output logic signed [out_w(DSIZE)-1:0]   sum
);

    localparam int OW = out_w(DSIZE);

    logic signed [DSIZE:0]  pre;
    logic signed [OW-1:0]   pre_ext;
    logic signed [OW-1:0]   coef_ext;
    logic signed [OW-1:0]   prod;
    logic signed [OW-1:0]   acc_q;
    logic signed [OW-1:0]   acc_d;

    // Operands are widened by one bit first so the pair sum never wraps.
    assign pre      = {op_a[DSIZE-1], op_a} + {op_b[DSIZE-1], op_b};
    assign pre_ext  = {{(OW-DSIZE-1){pre[DSIZE]}}, pre};
    assign coef_ext = {{(OW-CW){coef[CW-1]}}, coef};
    assign prod     = pre_ext * coef_ext;
    assign sum      = acc_q + prod;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge fast_clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rcosine_serial_fir.sv
// 9-tap symmetric raised-cosine FIR, one shared multiplier, 5 steps/sample.
//   fast_clk : processing clock, 5x sample rate
//   n_rst    : asynchronous active-low reset
//   din_en   : one-cycle sample strobe
//   din      : signed input sample, taken only when din_en = 1
//   dout     : signed registered result, updated when step 4 completes
module rcosine_serial_fir
    import rcosine_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic                             fast_clk,
    input  logic                             n_rst,
    input  logic                             din_en,
    input  logic signed [DSIZE-1:0]          din,
    output logic signed [out_w(DSIZE)-1:0]   dout
);

    localparam int OW = out_w(DSIZE);

    localparam logic [2:0] ST_0 = 3'd0;
    localparam logic [2:0] ST_1 = 3'd1;
    localparam logic [2:0] ST_2 = 3'd2;
    localparam logic [2:0] ST_3 = 3'd3;
    localparam logic [2:0] ST_4 = 3'd4;

    logic signed [DSIZE-1:0] x_q [NTAP];
    logic signed [DSIZE-1:0] x_d [NTAP];
    logic [2:0]              step_q, step_d;
    logic                    busy_q, busy_d;
    logic signed [OW-1:0]    dout_q, dout_d;

    logic signed [DSIZE-1:0] op_a;
    logic signed [DSIZE-1:0] op_b;
    logic signed [CW-1:0]    op_h;
    logic signed [OW-1:0]    mac_sum;

    // Tap shift register.
    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            x_d[k] = x_q[k];
        end
        if (din_en) begin
            x_d[0] = din;
            for (int k = 1; k < NTAP; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    // Operand / coefficient selection for the folded step.
    always_comb begin
        op_a = x_q[4];
        op_b = '0;
        op_h = H4;
        case (step_q)
            ST_0: begin op_a = x_q[0]; op_b = x_q[8]; op_h = H0; end
            ST_1: begin op_a = x_q[1]; op_b = x_q[7]; op_h = H1; end
            ST_2: begin op_a = x_q[2]; op_b = x_q[6]; op_h = H2; end
            ST_3: begin op_a = x_q[3]; op_b = x_q[5]; op_h = H3; end
            default: ;
        endcase
    end

    // Step controller and output register. A strobe always restarts at
    // step 0; dout only commits when step 4 actually executes, so an
    // early strobe silently drops the partial sum while a strobe
    // coincident with step 4 still commits from the pre-shift taps.
    always_comb begin
        step_d = step_q;
        busy_d = busy_q;
        dout_d = dout_q;
        if (busy_q && (step_q == ST_4)) begin
            dout_d = mac_sum;
        end
        if (din_en) begin
            busy_d = 1'b1;
            step_d = ST_0;
        end else if (busy_q) begin
            if (step_q == ST_4) begin
                busy_d = 1'b0;
                step_d = ST_0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NTAP; k++) begin
                x_q[k] <= '0;
            end
            step_q <= ST_0;
            busy_q <= 1'b0;
            dout_q <= '0;
        end else begin
            for (int k = 0; k < NTAP; k++) begin
                x_q[k] <= x_d[k];
            end
            step_q <= step_d;
            busy_q <= busy_d;
            dout_q <= dout_d;
        end
    end

    rcosine_mac #(
        .DSIZE (DSIZE)
    ) u_mac (
        .fast_clk (fast_clk),
        .n_rst    (n_rst),
        .clr      (din_en),
        .en       (busy_q),
        .op_a     (op_a),
        .op_b     (op_b),
        .coef     (op_h),
        .sum      (mac_sum)
    );

    assign dout = dout_q;

endmodule

// File: tb/tb_rcosine_serial_fir.sv
// Self-checking bench for rcosine_serial_fir: directed impulse/DC/ramp,
// early-strobe and reset cases plus randomized strobe spacing, compared
// every cycle against a convolution model of the filter.
module tb_rcosine_serial_fir;

    localparam int DSIZE = 8;
    localparam int OW    = 2 * DSIZE + 3;

    logic                    fast_clk;
    logic                    n_rst;
    logic                    din_en;
    logic signed [DSIZE-1:0] din;
    logic signed [OW-1:0]    dout;

    int total = 0;
    int bad   = 0;

    rcosine_serial_fir #(
        .DSIZE (DSIZE)
    ) dut (
        .fast_clk (fast_clk),
        .n_rst    (n_rst),
        .din_en   (din_en),
        .din      (din),
        .dout     (dout)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    // Reference model: sample history, newest first, and a pending result
    // that becomes visible five edges after its capturing strobe.
    int h [9] = '{0, -6, 0, 38, 64, 38, 0, -6, 0};
    int m_taps [9];
    bit m_pend;
    int m_age;
    int exp_dout;

    task automatic check_val(input string tag, input int obs, input int expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic int conv();
        int s = 0;
        for (int k = 0; k < 9; k++) s += h[k] * m_taps[k];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_taps[k] = 0;
        m_pend   = 1'b0;
        m_age    = 0;
        exp_dout = 0;
    endtask

    task automatic model_edge(input bit en, input int val);
        bit done;
        if (!n_rst) begin
            model_reset();
            return;
        end
        done = m_pend && (m_age == 4);
        if (done) exp_dout = conv();
        if (en) begin
            for (int k = 8; k > 0; k--) m_taps[k] = m_taps[k-1];
            m_taps[0] = val;
            m_pend = 1'b1;
            m_age  = 0;
        end else if (m_pend) begin
            if (done) m_pend = 1'b0;
            else m_age++;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input bit en, input int val);
        din_en = en;
        din    = DSIZE'(val);
        @(posedge fast_clk);
        model_edge(en, val);
        #1;
        check_val("dout", int'(dout), exp_dout);
        @(negedge fast_clk);
    endtask

    task automatic rnd_din_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, int'($urandom_range(255)) - 128);
    endtask

    // Strobe then four idle cycles: nominal 5-cycle spacing.
    task automatic strobe5(input int val);
        tick(1'b1, val);
        rnd_din_idle(4);
    endtask

    int imp_tab [10] = '{0, -6, 0, 38, 64, 38, 0, -6, 0, 0};
    int dc_val [3]   = '{100, -128, 127};
    int dc_exp [3]   = '{12800, -16384, 16256};

    initial begin
        n_rst  = 1'b0;
        din_en = 1'b0;
        din    = '0;
        model_reset();
        @(negedge fast_clk);

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(1)), int'($urandom_range(255)) - 128);
            check_val("rst_dout", int'(dout), 0);
        end
        n_rst = 1'b1;

        // Impulse: each strobe's edge also commits the previous sequence.
        for (int s = 0; s <= 10; s++) begin
            tick(1'b1, (s == 0) ? 1 : 0);
            if (s >= 1) check_val("impulse", int'(dout), imp_tab[s-1]);
            rnd_din_idle(4);
        end

        // DC levels.
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 12; s++) strobe5(dc_val[d]);
            tick(1'b0, 0);
            check_val("dc", int'(dout), dc_exp[d]);
        end

        // Ramp.
        for (int s = 0; s < 128; s++) strobe5(s);
        tick(1'b0, 0);

        // Early strobe three cycles after the previous one.
        strobe5(50);
        tick(1'b1, 20);
        rnd_din_idle(2);
        tick(1'b1, -70);
        rnd_din_idle(4);
        tick(1'b0, 0);
        rnd_din_idle(3);

        // Randomized spacing: early, coincident and idle-gap cases.
        for (int s = 0; s < 150; s++) begin
            tick(1'b1, int'($urandom_range(255)) - 128);
            rnd_din_idle(int'($urandom_range(6)));
        end
        rnd_din_idle(6);

        // Reset in the middle of a sequence.
        for (int s = 0; s < 10; s++) strobe5(90 - s);
        tick(1'b1, 77);
        rnd_din_idle(2);
        n_rst = 1'b0;
        model_reset();
        #1;
        check_val("midrst_dout", int'(dout), 0);
        check_val("midrst_tap0", int'(dut.x_q[0]), 0);
        check_val("midrst_tap8", int'(dut.x_q[8]), 0);
        @(negedge fast_clk);
        tick(1'b1, 33);
        n_rst = 1'b1;
        for (int s = 0; s < 12; s++) strobe5(int'($urandom_range(255)) - 128);
        tick(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
